pic_irq_mask_unit: RTL and testbench

- Parametrised successor to the 8259A-style interrupt mask register.
- Registers the interrupt request lines into IRR in edge or level mode, and gates them with a writable IMR.
- Resolves priority with fully-nested and optional rotating priority, and raises a registered interrupt request with a vector.
- Tracks in-service levels (ISR) through an INTA acknowledge and EOI handshake. Sits between the IR pins and the control/cascade logic of the PIC.

---
 rtl/pic_irq_mask_unit.sv | 139 +++++++++++++
 tb/tb_pic_irq_mask_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_irq_mask_unit.sv
`default_nettype none
// ============================================================================
// Module   : pic_irq_mask_unit
// Brief    : IRR/IMR/ISR core of an 8259A-style PIC with nested and rotating
//            priority and a registered request/vector towards the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module pic_irq_mask_unit #(
  parameter  int NUM_IRQ = 8,
  localparam int VW      = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic               ltim,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               inta_ack,
  input  logic               auto_eoi,
  input  logic               eoi,
  input  logic               eoi_specific,
  input  logic [VW-1:0]      eoi_level,
  input  logic               rotate,
  output logic [NUM_IRQ-1:0] imr,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic               int_req,
  output logic [VW-1:0]      int_vector
);

  localparam logic [NUM_IRQ-1:0] C_ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] ir_prev_q, ir_prev_d;
  logic [VW-1:0]      pb_q, pb_d;
  logic               int_req_q, int_req_d;
  logic [VW-1:0]      int_vector_q, int_vector_d;

  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_ack_mask;
  logic [NUM_IRQ-1:0] w_eoi_mask;
  logic               w_ack;
  logic               w_win_valid;
  logic [VW-1:0]      w_win_lvl;
  logic [VW-1:0]      w_isr_lvl;
  int                 w_win_rank;
  int                 w_isr_rank;

  // Rank 0 is the highest priority; pb names the level that currently holds it.
  function automatic int rank_of(input int lvl, input int base);
    int r;
    r = lvl - base;
    if (r < 0) r = r + NUM_IRQ;
    return r;
  endfunction

  function automatic logic [VW-1:0] next_lvl(input logic [VW-1:0] lvl);
    if (int'(lvl) == NUM_IRQ - 1) return '0;
    return lvl + VW'(1);
  endfunction

  always_comb begin
    w_cand     = irr_q & ~imr_q;
    w_win_rank = NUM_IRQ;
    w_win_lvl  = '0;
    w_isr_rank = NUM_IRQ;
    w_isr_lvl  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_cand[i] && (rank_of(i, int'(pb_q)) < w_win_rank)) begin
        w_win_rank = rank_of(i, int'(pb_q));
        w_win_lvl  = VW'(i);
      end
      if (isr_q[i] && (rank_of(i, int'(pb_q)) < w_isr_rank)) begin
        w_isr_rank = rank_of(i, int'(pb_q));
        w_isr_lvl  = VW'(i);
      end
    end
    // An empty candidate set leaves w_win_rank at NUM_IRQ, which never wins.
    w_win_valid = (w_win_rank < w_isr_rank);
  end

  always_comb begin
    w_ack      = inta_ack & int_req_q;
    w_ack_mask = w_ack ? (C_ONE << int_vector_q) : '0;
    w_eoi_mask = '0;
    pb_d       = pb_q;
    if (eoi) begin
      if (eoi_specific) begin
        if (int'(eoi_level) < NUM_IRQ) begin
          w_eoi_mask = C_ONE << eoi_level;
          if (rotate) pb_d = next_lvl(eoi_level);
        end
      end else if (|isr_q) begin
        w_eoi_mask = C_ONE << w_isr_lvl;
        if (rotate) pb_d = next_lvl(w_isr_lvl);
      end
    end
  end

  always_comb begin
    imr_d     = mask_wr ? mask_wdata : imr_q;
    ir_prev_d = ir;
    if (ltim) irr_d = ir & ~w_ack_mask;
    else      irr_d = (irr_q & ~w_ack_mask) | (ir & ~ir_prev_q);
    // An acknowledge setting a bit wins over an EOI clearing it in the same cycle.
    isr_d        = (isr_q & ~w_eoi_mask) | (auto_eoi ? '0 : w_ack_mask);
    int_req_d    = w_win_valid & ~w_ack;
    int_vector_d = int_req_d ? w_win_lvl : int_vector_q;
  end

  always_ff @(posedge clk) begin
    ir_prev_q <= ir_prev_d;
    if (rst) begin
      imr_q        <= '0;
      irr_q        <= '0;
      isr_q        <= '0;
      pb_q         <= '0;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
    end else begin
      imr_q        <= imr_d;
      irr_q        <= irr_d;
      isr_q        <= isr_d;
      pb_q         <= pb_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
    end
  end

  assign imr        = imr_q;
  assign irr        = irr_q;
  assign isr        = isr_q;
  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;

endmodule
`default_nettype wire

// File: tb/tb_pic_irq_mask_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_irq_mask_unit
// Brief    : Scoreboard bench for pic_irq_mask_unit (NUM_IRQ = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_irq_mask_unit;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] imr;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       req;
    logic [2:0] vec;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       ltim;
  logic       mask_wr;
  logic [7:0] mask_wdata;
  logic       inta_ack;
  logic       auto_eoi;
  logic       eoi;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate;
  logic [7:0] imr;
  logic [7:0] irr;
  logic [7:0] isr;
  logic       int_req;
  logic [2:0] int_vector;

  obs_t exp_q[$];
  obs_t e;
  obs_t got;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] m_imr, m_irr, m_isr, m_prev;
  int         m_pb, m_vec;
  bit         m_req;

  pic_irq_mask_unit #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .ir(ir), .ltim(ltim),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .inta_ack(inta_ack), .auto_eoi(auto_eoi),
    .eoi(eoi), .eoi_specific(eoi_specific), .eoi_level(eoi_level), .rotate(rotate),
    .imr(imr), .irr(irr), .isr(isr), .int_req(int_req), .int_vector(int_vector)
  );

  always #5 clk = ~clk;

  // Reference model: advance one clock with the inputs currently driven,
  // push the expected post-edge outputs, then move past the edge.
  task automatic tick();
    logic [7:0] cand, ackm, eclr, n_irr, n_isr, n_imr;
    int wl, wr, il, irk, l, n_pb, n_vec;
    bit n_req, ackd;
    if (rst) begin
      m_imr = '0; m_irr = '0; m_isr = '0; m_pb = 0; m_req = 0; m_vec = 0;
    end else begin
      ackd = inta_ack && m_req;
      ackm = ackd ? (8'h01 << m_vec) : 8'h00;
      cand = m_irr & ~m_imr;
      wr = N; irk = N; wl = 0; il = 0;
      for (int r = N - 1; r >= 0; r--) begin
        l = (m_pb + r) % N;
        if (cand[l])  begin wr  = r; wl = l; end
        if (m_isr[l]) begin irk = r; il = l; end
      end
      n_req = (wr < irk) && !ackd;
      n_vec = n_req ? wl : m_vec;
      n_irr = ltim ? (ir & ~ackm) : ((m_irr & ~ackm) | (ir & ~m_prev));
      eclr = 8'h00;
      n_pb = m_pb;
      if (eoi) begin
        if (eoi_specific) begin
          eclr = 8'h01 << eoi_level;
          if (rotate) n_pb = (int'(eoi_level) + 1) % N;
        end else if (irk < N) begin
          eclr = 8'h01 << il;
          if (rotate) n_pb = (il + 1) % N;
        end
      end
      n_isr = (m_isr & ~eclr) | (auto_eoi ? 8'h00 : ackm);
      n_imr = mask_wr ? mask_wdata : m_imr;
      m_imr = n_imr; m_irr = n_irr; m_isr = n_isr; m_pb = n_pb; m_req = n_req; m_vec = n_vec;
    end
    m_prev = ir;
    exp_q.push_back({m_imr, m_irr, m_isr, m_req, 3'(m_vec)});
    @(posedge clk);
    #1;
    inta_ack = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; rotate = 1'b0; mask_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL reset[%0d]: got %h required %h", s, got, e); end
      if (s == 1) begin
        vectors++;
        if ({imr, irr, isr, int_req, int_vector} !== 28'h0) begin
          miscompares++;
          $display("FAIL reset_zero: got %h required 0", {imr, irr, isr, int_req, int_vector});
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_edge();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: ir = 8'h04;
        2: inta_ack = 1'b1;
        3: begin ir = 8'h00; eoi = 1'b1; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL edge[%0d]: got %h required %h", s, got, e); end
      if (s == 0) begin
        vectors++;
        if (irr !== 8'h04) begin miscompares++; $display("FAIL edge_irr: got %h required 04", irr); end
      end
      if (s == 1) begin
        vectors++;
        if (int_req !== 1'b1 || int_vector !== 3'd2) begin
          miscompares++; $display("FAIL edge_req: got req=%b vec=%0d required req=1 vec=2", int_req, int_vector);
        end
      end
      if (s == 2) begin
        vectors++;
        if (isr !== 8'h04 || int_req !== 1'b0) begin
          miscompares++; $display("FAIL edge_ack: got isr=%h req=%b required isr=04 req=0", isr, int_req);
        end
      end
    end
  endtask

  task automatic test_mask();
    for (int s = 0; s < 10; s++) begin
      case (s)
        0: begin mask_wr = 1'b1; mask_wdata = 8'hAA; end
        1: ir = 8'h22;
        4: begin mask_wr = 1'b1; mask_wdata = 8'h00; end
        6: inta_ack = 1'b1;
        7: eoi = 1'b1;
        9: begin inta_ack = 1'b1; ir = 8'h00; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL mask[%0d]: got %h required %h", s, got, e); end
      if (s == 3) begin
        vectors++;
        if (irr !== 8'h22 || int_req !== 1'b0) begin
          miscompares++; $display("FAIL mask_hold: got irr=%h req=%b required irr=22 req=0", irr, int_req);
        end
      end
      if (s == 5) begin
        vectors++;
        if (int_req !== 1'b1 || int_vector !== 3'd1) begin
          miscompares++; $display("FAIL mask_release: got req=%b vec=%0d required req=1 vec=1", int_req, int_vector);
        end
      end
      if (s == 9) begin
        vectors++;
        if (isr !== 8'h20) begin miscompares++; $display("FAIL mask_isr5: got %h required 20", isr); end
      end
    end
  endtask

  task automatic test_nesting();
    for (int s = 0; s < 11; s++) begin
      case (s)
        0: ir = 8'h80;
        3: ir = 8'h88;
        5: inta_ack = 1'b1;
        6: eoi = 1'b1;
        7: begin eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5; end
        9: begin inta_ack = 1'b1; ir = 8'h00; end
        10: begin eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd7; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL nest[%0d]: got %h required %h", s, got, e); end
      if (s == 2) begin
        vectors++;
        if (int_req !== 1'b0) begin miscompares++; $display("FAIL nest_block: got req=%b required 0", int_req); end
      end
      if (s == 4) begin
        vectors++;
        if (int_req !== 1'b1 || int_vector !== 3'd3) begin
          miscompares++; $display("FAIL nest_preempt: got req=%b vec=%0d required req=1 vec=3", int_req, int_vector);
        end
      end
      if (s == 5 || s == 6) begin
        vectors++;
        if (isr !== ((s == 5) ? 8'h28 : 8'h20)) begin
          miscompares++; $display("FAIL nest_isr[%0d]: got %h required %h", s, isr, (s == 5) ? 8'h28 : 8'h20);
        end
      end
    end
  endtask

  task automatic test_rotation();
    for (int s = 0; s < 10; s++) begin
      case (s)
        0: begin rst = 1'b1; ir = 8'h00; end
        1: begin rst = 1'b0; ir = 8'h10; end
        3: begin inta_ack = 1'b1; ir = 8'h00; end
        4: begin eoi = 1'b1; rotate = 1'b1; end
        5: ir = 8'h50;
        7: begin inta_ack = 1'b1; ir = 8'h00; end
        8: eoi = 1'b1;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rotate[%0d]: got %h required %h", s, got, e); end
      if (s == 6) begin
        vectors++;
        if (int_req !== 1'b1 || int_vector !== 3'd6) begin
          miscompares++; $display("FAIL rotate_winner: got req=%b vec=%0d required req=1 vec=6", int_req, int_vector);
        end
      end
    end
  endtask

  task automatic test_level_auto_eoi();
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin rst = 1'b1; ir = 8'h00; ltim = 1'b1; auto_eoi = 1'b1; end
        1: begin rst = 1'b0; ir = 8'h01; end
        3: inta_ack = 1'b1;
        6: ir = 8'h00;
        7: begin ltim = 1'b0; auto_eoi = 1'b0; end
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL level[%0d]: got %h required %h", s, got, e); end
      if (s == 3) begin
        vectors++;
        if (irr !== 8'h00 || isr !== 8'h00 || int_req !== 1'b0) begin
          miscompares++; $display("FAIL level_ack: got irr=%h isr=%h req=%b required 00 00 0", irr, isr, int_req);
        end
      end
      if (s == 5) begin
        vectors++;
        if (irr !== 8'h01 || int_req !== 1'b1 || int_vector !== 3'd0) begin
          miscompares++; $display("FAIL level_rearm: got irr=%h req=%b vec=%0d required 01 1 0", irr, int_req, int_vector);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin rst = 1'b1; ir = 8'h00; end
        1: begin rst = 1'b0; ir = 8'h02; end
        2: ir = 8'h00;
        3: begin
          inta_ack = 1'b1; ir = 8'h02;
          eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1;
        end
        4: begin mask_wr = 1'b1; mask_wdata = 8'h08; ir = 8'h0A; end
        5: eoi = 1'b1;
        7: ir = 8'h00;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL b2b[%0d]: got %h required %h", s, got, e); end
      if (s == 3) begin
        vectors++;
        if (irr !== 8'h02 || isr !== 8'h02 || int_req !== 1'b0) begin
          miscompares++; $display("FAIL b2b_setwins: got irr=%h isr=%h req=%b required 02 02 0", irr, isr, int_req);
        end
      end
      if (s == 4) begin
        vectors++;
        if (irr !== 8'h0A) begin miscompares++; $display("FAIL b2b_maskedge: got irr=%h required 0a", irr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 13; s++) begin
      case (s)
        0: begin rst = 1'b1; ir = 8'h00; end
        1: begin
          rst = 1'b0; eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0; rotate = 1'b1;
          mask_wr = 1'b1; mask_wdata = 8'h80;
        end
        2: ir = 8'h81;
        4: begin inta_ack = 1'b1; mask_wr = 1'b1; mask_wdata = 8'h00; end
        6: inta_ack = 1'b1;
        7: ir = 8'h83;
        9: rst = 1'b1;
        10: rst = 1'b0;
        12: ir = 8'h00;
        default: ;
      endcase
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rstmid[%0d]: got %h required %h", s, got, e); end
      if (s == 8) begin
        vectors++;
        if (isr !== 8'h81 || int_req !== 1'b1 || int_vector !== 3'd1) begin
          miscompares++; $display("FAIL rstmid_setup: got isr=%h req=%b vec=%0d required 81 1 1", isr, int_req, int_vector);
        end
      end
      if (s == 9 || s == 11) begin
        vectors++;
        if ({irr, isr, int_req, int_vector} !== 20'h0) begin
          miscompares++; $display("FAIL rstmid_clear[%0d]: got irr=%h isr=%h req=%b required all 0", s, irr, isr, int_req);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) ltim = ~ltim;
      ir = ir ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask_wr = ($urandom_range(0, 9) == 0);
      mask_wdata = 8'($urandom) & 8'($urandom);
      inta_ack = ($urandom_range(0, 9) < 4);
      auto_eoi = ($urandom_range(0, 3) == 0);
      eoi = ($urandom_range(0, 3) == 0);
      eoi_specific = $urandom_range(0, 1) == 1;
      eoi_level = 3'($urandom_range(0, 7));
      rotate = $urandom_range(0, 1) == 1;
      tick();
      e = exp_q.pop_front(); got = {imr, irr, isr, int_req, int_vector}; vectors++;
      if (got !== e) begin miscompares++; $display("FAIL random[%0d]: got %h required %h", s, got, e); end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ir = 8'h00; ltim = 1'b0; mask_wr = 1'b0; mask_wdata = 8'h00;
    inta_ack = 1'b0; auto_eoi = 1'b0; eoi = 1'b0; eoi_specific = 1'b0;
    eoi_level = 3'd0; rotate = 1'b0;
    m_imr = '0; m_irr = '0; m_isr = '0; m_prev = '0; m_pb = 0; m_req = 0; m_vec = 0;
    test_reset();
    test_edge();
    test_mask();
    test_nesting();
    test_rotation();
    test_level_auto_eoi();
    test_back_to_back();
    test_reset_mid();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
